// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment codes, capture FSM states, decode payload.
package seven_seg_pkg;

  localparam int unsigned N_DIGITS = 8;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned SEG_W    = 7;

  // Active-high gfedcba patterns, common to the display driver and this monitor
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} st_t;

  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             blank;
    logic             invalid;
  } seg_dec_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational reverse of the segment table: active-high pattern -> nibble/blank/invalid.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_dec_t         dec
);

  always_comb begin
    dec = '{nibble: '0, blank: 1'b0, invalid: 1'b0};
    case (seg)
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_A:     dec.nibble = 4'hA;
      SEG_B:     dec.nibble = 4'hB;
      SEG_C:     dec.nibble = 4'hC;
      SEG_D:     dec.nibble = 4'hD;
      SEG_E:     dec.nibble = 4'hE;
      SEG_F:     dec.nibble = 4'hF;
      SEG_BLANK: dec.blank  = 1'b1;
      default:   dec.invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus monitor: reassembles the 8-digit displayed value.
// Optional SEVEN_SEG_CAPTURE_ERR_EN: flag invalid patterns / multi-low anodes on Error.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [N_DIGITS-1:0]       SevenSegAn,
  input  logic [SEG_W-1:0]          SevenSegCat,
  output logic [N_DIGITS*NIB_W-1:0] Value,
  output logic [N_DIGITS-1:0]       BlankMask,
  output logic                      FrameValid,
  output logic                      Stale,
  output logic                      Error
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CAP_AT     = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] TMO_MAX    = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] TMO_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [N_DIGITS-1:0]       an_q, an_prev, an_act;
  logic [SEG_W-1:0]          cat_q, seg_act;
  logic [CNT_W-1:0]          settle_cnt, cnt_cur, cnt_next;
  logic [IDLE_W-1:0]         idle_cnt;
  logic [N_DIGITS*NIB_W-1:0] work, work_n;
  logic [N_DIGITS-1:0]       wblank, wblank_n, seen, seen_n;
  logic                      an_chg, an_one, an_multi, settled, dwell_open;
  logic                      cap, cap_ok, frame_done, tmo;
  st_t                       st, st_n;
  seg_dec_t                  dec;

  assign seg_act = ~cat_q;

  seven_seg_decode u_decode (
    .seg (seg_act),
    .dec (dec)
  );

  // Dwell tracking: counter view is cleared in the same cycle the anode changes
  always_comb begin
    an_act     = ~an_q;
    an_chg     = (an_q != an_prev);
    an_one     = $onehot(an_act);
    an_multi   = (an_act != '0) && !an_one;
    cnt_cur    = an_chg ? '0 : settle_cnt;
    cnt_next   = (cnt_cur < SETTLE_MAX) ? CNT_W'(cnt_cur + CNT_W'(1)) : cnt_cur;
    settled    = (cnt_cur == CAP_AT);
    dwell_open = an_chg || (st != CAPTURED);
    cap        = settled && an_one && dwell_open;
    tmo        = !cap && (idle_cnt == TMO_LAST);
  end

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  assign cap_ok = cap && !dec.invalid;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Error <= 1'b0;
    end else if ((cap && dec.invalid) || (settled && an_multi)) begin
      Error <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign cap_ok     = cap;
  assign Error      = 1'b0;
  assign unused_err = ^{dec.invalid, an_multi};
`endif

  // Working frame with bypass so the final digit lands in the committed value
  always_comb begin
    work_n   = work;
    wblank_n = wblank;
    seen_n   = seen;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (cap_ok && an_act[i]) begin
        work_n[NIB_W*i +: NIB_W] = dec.nibble;
        wblank_n[i]              = dec.blank;
        seen_n[i]                = 1'b1;
      end
    end
    frame_done = (seen_n == '1);
  end

  always_comb begin
    st_n = st;
    case (st)
      IDLE: begin
        if (cap)         st_n = CAPTURED;
        else if (an_one) st_n = SETTLE;
      end
      SETTLE: begin
        if (cap)          st_n = CAPTURED;
        else if (!an_one) st_n = IDLE;
      end
      CAPTURED: begin
        if (an_chg) begin
          if (cap)         st_n = CAPTURED;
          else if (an_one) st_n = SETTLE;
          else             st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) st <= IDLE;
    else       st <= st_n;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      an_q       <= '1;
      an_prev    <= '1;
      cat_q      <= '1;
      settle_cnt <= '0;
      idle_cnt   <= '0;
      work       <= '0;
      wblank     <= '0;
      seen       <= '0;
      Value      <= '0;
      BlankMask  <= '0;
      FrameValid <= 1'b0;
      Stale      <= 1'b0;
    end else begin
      an_q       <= SevenSegAn;
      cat_q      <= SevenSegCat;
      an_prev    <= an_q;
      settle_cnt <= cnt_next;
      work       <= work_n;
      wblank     <= wblank_n;
      FrameValid <= frame_done;
      if (cap)                  idle_cnt <= '0;
      else if (idle_cnt != TMO_MAX) idle_cnt <= IDLE_W'(idle_cnt + IDLE_W'(1));
      if (frame_done) begin
        Value     <= work_n;
        BlankMask <= wblank_n;
        seen      <= '0;
        Stale     <= 1'b0;
      end else if (tmo) begin
        seen  <= '0;
        Stale <= 1'b1;
      end else begin
        seen <= seen_n;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture against a dwell-level reference model.
module tb_seven_seg_capture;

  localparam int S = 3;
  localparam int T = 1024;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;
  logic [31:0] Value;
  logic [7:0]  BlankMask;
  logic        FrameValid, Stale, Error;

  always #5 CLK = ~CLK;

  seven_seg_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .SevenSegAn  (SevenSegAn),
    .SevenSegCat (SevenSegCat),
    .Value       (Value),
    .BlankMask   (BlankMask),
    .FrameValid  (FrameValid),
    .Stale       (Stale),
    .Error       (Error)
  );

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;

  // Reference model state, advanced once per completed dwell
  logic [3:0]  m_nib [8];
  bit          m_blk [8];
  bit   [7:0]  m_seen;
  logic [31:0] m_value;
  logic [7:0]  m_bmask;
  int          m_frames = 0;
  int          m_idle;
  bit          m_stale, m_err;

  always @(negedge CLK) if (FrameValid === 1'b1) fv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] seg, output logic [3:0] nib,
                                     output bit blk, output bit inv);
    nib = 4'h0; blk = 1'b0; inv = 1'b1;
    if (seg == 7'h00) begin
      blk = 1'b1; inv = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) if (codes[k] == seg) begin nib = 4'(k); inv = 1'b0; end
    end
  endfunction

  function automatic void model_clear();
    m_seen = '0; m_value = '0; m_bmask = '0; m_stale = 1'b0; m_err = 1'b0; m_idle = 0;
  endfunction

  // Hold one anode/segment pattern for len cycles, then apply the dwell to the model
  task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input int len);
    logic [3:0] nib;
    bit blk, inv;
    int lows;
    SevenSegAn  = an;
    SevenSegCat = ~seg;
    repeat (len) @(negedge CLK);
    lows = $countones(~an);
    if (lows == 1 && len >= S) begin
      ref_decode(seg, nib, blk, inv);
      m_idle = len - S;
      if (ERR_EN && inv) begin
        m_err = 1'b1;
      end else begin
        for (int k = 0; k < 8; k++) if (!an[k]) begin
          m_nib[k] = nib; m_blk[k] = blk; m_seen[k] = 1'b1;
        end
        if (m_seen == 8'hFF) begin
          for (int k = 0; k < 8; k++) begin
            m_value[4*k +: 4] = m_nib[k];
            m_bmask[k]        = m_blk[k];
          end
          m_frames++;
          m_seen  = '0;
          m_stale = 1'b0;
        end
      end
    end else begin
      if (ERR_EN && lows > 1 && len >= S) m_err = 1'b1;
      m_idle += len;
      if (m_idle >= T) begin m_seen = '0; m_stale = 1'b1; end
    end
  endtask

  task automatic digit(input int i, input logic [6:0] seg, input int len);
    logic [7:0] one = 8'b1;
    dwell(~(one << i), seg, len);
  endtask

  task automatic scan_value(input logic [31:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) digit(i, codes[v[4*i +: 4]], 4);
  endtask

  task automatic check_all(input string tag);
    repeat (2) @(negedge CLK);
    check({tag, ".value"},  Value,              m_value);
    check({tag, ".blank"},  32'(BlankMask),     32'(m_bmask));
    check({tag, ".frames"}, 32'(fv_cnt),        32'(m_frames));
    check({tag, ".stale"},  32'(Stale),         32'(m_stale));
    check({tag, ".error"},  32'(Error),         32'(m_err));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    SevenSegAn = 8'hFF;
    SevenSegCat = 7'h7F;
    repeat (3) @(negedge CLK);
    model_clear();
    check("reset.value", Value, 32'h0);
    check("reset.blank", 32'(BlankMask), 32'h0);
    check("reset.fv",    32'(FrameValid), 32'h0);
    check("reset.stale", 32'(Stale), 32'h0);
    check("reset.error", 32'(Error), 32'h0);
    Reset = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  bm;
    logic [7:0]  ml;
    int          r, j;

    @(negedge CLK);
    do_reset();

    scan_value(32'h12345678, 0, 7);
    check_all("scan12345678");
    check("scan.value_const", Value, 32'h12345678);

    for (int i = 0; i < 8; i++) digit(i, (i >= 4) ? 7'h00 : ((i == 0) ? codes[10] : codes[0]), 4);
    check_all("blank");
    check("blank.mask_const", 32'(BlankMask), 32'hF0);

    v = 32'h87654321;
    for (int i = 0; i < 8; i++) digit(i, codes[v[4*i +: 4]], (i == 3) ? 2 : 4);
    check_all("short.partial");
    digit(3, codes[v[15:12]], 3);
    check_all("short.done");

    v = 32'h9ABCDEF5;
    digit(0, 7'h49, 4);
    scan_value(v, 1, 7);
    check_all("invalid");
    scan_value(32'h0BADF00D, 0, 7);
    check_all("invalid.after");

    for (int f = 0; f < 20; f++) begin
      v  = $urandom;
      bm = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 7);
        if (r < 2) begin
          digit((i + 4) % 8, codes[$urandom_range(0, 15)], $urandom_range(1, S - 1));
        end else if (r == 2) begin
          j  = (i + $urandom_range(1, 7)) % 8;
          ml = ~((8'b1 << i) | (8'b1 << j));
          dwell(ml, codes[$urandom_range(0, 15)], $urandom_range(1, S + 2));
        end
        digit(i, bm[i] ? 7'h00 : codes[v[4*i +: 4]], $urandom_range(S, S + 3));
      end
      check_all($sformatf("rand%0d", f));
    end

    scan_value(32'h00C0FFEE, 0, 5);
    dwell(8'hFF, 7'h00, 1100);
    check_all("timeout.stale");
    scan_value(32'h00C0FFEE, 6, 7);
    check_all("timeout.seen_cleared");
    scan_value(32'h13579BDF, 0, 7);
    check_all("timeout.recover");

    scan_value(32'h2468ACE0, 0, 3);
    do_reset();
    scan_value(32'h2468ACE0, 4, 7);
    check_all("reset_mid.partial");
    scan_value(32'h2468ACE0, 0, 7);
    check_all("reset_mid.recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
